// File: rtl/fifo_write_logic.sv
// Write-domain control for the async packet FIFO: binary write address, Gray write pointer and registered full flag.
// Optional build macro FWL_OVERFLOW_CHECK_EN adds a simulation-only overflow monitor.
module fifo_write_logic #(
  parameter int PTR_SZ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rq2_raddr,
  output logic              wfull,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              dbg_state,
  output logic [PTR_SZ:0]   dbg_raddr
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PTR_SZ:0] wbin_q, wbin_d;
  logic [PTR_SZ:0] wgray_q, wgray_d;
  logic            wfull_q, wfull_d;
  logic [PTR_SZ:0] full_cmp;
  logic [PTR_SZ:0] raddr;

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  always_comb begin
    write_en = winc & ~wfull_q & rst;
    wbin_d   = wbin_q + {{PTR_SZ{1'b0}}, write_en};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    full_cmp = {~rq2_raddr[PTR_SZ:PTR_SZ-1], rq2_raddr[PTR_SZ-2:0]};
    wfull_d  = (wgray_d == full_cmp);
  end

  // Gray-to-binary of the synchronized read pointer, for visibility only.
  always_comb begin
    raddr = '0;
    for (int i = 0; i <= PTR_SZ; i++) begin
      raddr[i] = ^(rq2_raddr >> i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wfull_d)  state_d = FULL;
      FULL:    if (!wfull_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
      state_q <= state_d;
    end
  end

  assign wfull      = wfull_q;
  assign waddr      = wbin_q[PTR_SZ-1:0];
  assign waddr_gray = wgray_q;
  assign dbg_state  = state_q;
  assign dbg_raddr  = raddr;

`ifdef FWL_OVERFLOW_CHECK_EN
  logic [PTR_SZ:0] occupancy;
  assign occupancy = wbin_q - raddr;

  always @(posedge clk) begin
    if (rst) begin
      if (winc && wfull_q)
        $display("overflow attempt at %0t", $time);
      if (occupancy > {1'b1, {PTR_SZ{1'b0}}})
        $error("occupancy %0d exceeds depth at %0t", occupancy, $time);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_logic.sv
// Directed bench for fifo_write_logic at PTR_SZ=2 with hand-computed expectations.
module tb_fifo_write_logic;

  localparam int PTR_SZ = 2;

  logic              clk;
  logic              rst;
  logic              winc;
  logic [PTR_SZ:0]   rq2_raddr;
  logic              wfull;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ:0]   waddr_gray;
  logic              dbg_state;
  logic [PTR_SZ:0]   dbg_raddr;

  int n_checks = 0;
  int n_errors = 0;

  fifo_write_logic #(.PTR_SZ(PTR_SZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .winc       (winc),
    .rq2_raddr  (rq2_raddr),
    .wfull      (wfull),
    .write_en   (write_en),
    .waddr      (waddr),
    .waddr_gray (waddr_gray),
    .dbg_state  (dbg_state),
    .dbg_raddr  (dbg_raddr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One write pulse: winc set after a falling edge, strobe checked before the rising edge,
  // registered outputs checked 1 time unit after it.
  task automatic write_pulse(input logic exp_en, input logic [PTR_SZ-1:0] exp_addr,
                             input logic [PTR_SZ:0] exp_gray, input logic exp_full);
    @(negedge clk);
    winc = 1'b1;
    #1;
    check("write_en", write_en, exp_en);
    @(posedge clk);
    #1;
    winc = 1'b0;
    check("waddr", waddr, exp_addr);
    check("waddr_gray", waddr_gray, exp_gray);
    check("wfull", wfull, exp_full);
    check("state", dbg_state, exp_full);
  endtask

  logic [1:0]        exp_addr_tbl [4];
  logic [PTR_SZ:0]   exp_gray_tbl [4];

  initial begin
    exp_addr_tbl = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_gray_tbl = '{3'd1, 3'd3, 3'd2, 3'd6};

    rst = 1'b0;
    winc = 1'b0;
    rq2_raddr = '0;

    // reset held with winc toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      winc = ~winc;
      #1;
      check("rst_write_en", write_en, 1'b0);
      check("rst_waddr", waddr, 2'd0);
      check("rst_waddr_gray", waddr_gray, 3'd0);
      check("rst_wfull", wfull, 1'b0);
    end
    @(negedge clk);
    winc = 1'b0;
    rst = 1'b1;

    // fill: four writes
    for (int i = 0; i < 4; i++) begin
      write_pulse(1'b1, exp_addr_tbl[i], exp_gray_tbl[i], (i == 3));
    end

    // write while full is ignored
    write_pulse(1'b0, 2'd0, 3'd6, 1'b1);

    // read progress frees one slot
    @(negedge clk);
    rq2_raddr = 3'd1;
    #1;
    check("dbg_raddr", dbg_raddr, 3'd1);
    @(posedge clk);
    #1;
    check("wfull_after_read", wfull, 1'b0);
    check("state_after_read", dbg_state, 1'b0);
    write_pulse(1'b1, 2'd1, 3'd7, 1'b1);

    // read pointer steps back with winc asserted: no strobe this cycle
    @(negedge clk);
    rq2_raddr = 3'd0;
    winc = 1'b1;
    #1;
    check("back_write_en", write_en, 1'b0);
    check("back_wfull", wfull, 1'b1);
    check("back_waddr_gray", waddr_gray, 3'd7);

    // asynchronous reset mid-cycle while full
    rst = 1'b0;
    #1;
    check("arst_wfull", wfull, 1'b0);
    check("arst_waddr", waddr, 2'd0);
    check("arst_waddr_gray", waddr_gray, 3'd0);
    check("arst_write_en", write_en, 1'b0);
    check("arst_state", dbg_state, 1'b0);
    winc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    write_pulse(1'b1, 2'd1, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
